// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and op-decode helpers for the milano EX-stage MD unit
package milano_pkg;

    typedef enum logic [3:0] {
        MD_OP_NONE   = 4'd0,
        MD_OP_MUL    = 4'd1,
        MD_OP_MULH   = 4'd2,
        MD_OP_MULHSU = 4'd3,
        MD_OP_MULHU  = 4'd4,
        MD_OP_DIV    = 4'd5,
        MD_OP_DIVU   = 4'd6,
        MD_OP_REM    = 4'd7,
        MD_OP_REMU   = 4'd8
    } md_opt_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    localparam int unsigned MD_ITERS = 32;

    function automatic logic md_is_mul(md_opt_e op);
        return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU};
    endfunction

    function automatic logic md_is_div(md_opt_e op);
        return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
    endfunction

    function automatic logic md_a_signed(md_opt_e op);
        return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
    endfunction

    function automatic logic md_b_signed(md_opt_e op);
        return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// rtl/ex_div_core.sv - 32-step restoring divider on unsigned magnitudes, one quotient bit per cycle
module ex_div_core
    import milano_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] div_q;
    logic [5:0]  cnt_q;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // quotient/remainder are the post-step values so the owner can latch them on the final step
    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        fits      = (shifted >= {1'b0, div_q});
        diff      = shifted[31:0] - div_q;
        remainder = fits ? diff : shifted[31:0];
        quotient  = {quo_q[30:0], fits};
        done      = step && (cnt_q == 6'(MD_ITERS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt_q <= done ? 6'd0 : cnt_q + 6'd1;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle RV32M multiply/divide unit with stall request and one-cycle result pulse
module ex_mdu
    import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        md_sel_i,
    input  logic [31:0] md_operand_a_i,
    input  logic [31:0] md_operand_b_i,
    input  md_opt_e     md_operate_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        md_valid_o,
    output logic [31:0] md_result_o
);

    md_state_e   state_q;
    md_opt_e     op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        a_neg_q;
    logic        b_neg_q;

    logic        start_ok;
    logic        a_sgn;
    logic        b_sgn;
    logic        div_by_zero;
    logic        overflow;
    logic        is_special;
    logic [31:0] special_res;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_load;
    logic        div_clear;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [31:0] mul_res;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] div_res;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic        core_done;

    always_comb begin
        start_ok    = md_sel_i && (md_operate_i != MD_OP_NONE) && !flush_i
                      && (state_q == MD_IDLE);
        a_sgn       = md_a_signed(md_operate_i) && md_operand_a_i[31];
        b_sgn       = md_b_signed(md_operate_i) && md_operand_b_i[31];
        div_by_zero = (md_operand_b_i == 32'd0);
        overflow    = (md_operate_i inside {MD_OP_DIV, MD_OP_REM})
                      && (md_operand_a_i == 32'h8000_0000)
                      && (md_operand_b_i == 32'hFFFF_FFFF);
        is_special  = md_is_div(md_operate_i) && (div_by_zero || overflow);
        if (div_by_zero)
            special_res = (md_operate_i inside {MD_OP_DIV, MD_OP_DIVU}) ? 32'hFFFF_FFFF
                                                                       : md_operand_a_i;
        else
            special_res = (md_operate_i == MD_OP_DIV) ? 32'h8000_0000 : 32'd0;
        a_mag       = a_sgn ? -md_operand_a_i : md_operand_a_i;
        b_mag       = b_sgn ? -md_operand_b_i : md_operand_b_i;
        div_load    = start_ok && md_is_div(md_operate_i) && !is_special;
        div_clear   = flush_i && (state_q == MD_DIV);
    end

    // Sign-extending straight to 64 bits yields the same low 64 bits as the 33x33 product
    always_comb begin
        a_ext   = {{32{md_a_signed(op_q) & a_q[31]}}, a_q};
        b_ext   = {{32{md_b_signed(op_q) & b_q[31]}}, b_q};
        product = a_ext * b_ext;
        mul_res = (op_q == MD_OP_MUL) ? product[31:0] : product[63:32];
    end

    always_comb begin
        quo_fixed = (op_q == MD_OP_DIV && (a_neg_q ^ b_neg_q)) ? -core_quo : core_quo;
        rem_fixed = (op_q == MD_OP_REM && a_neg_q) ? -core_rem : core_rem;
        div_res   = (op_q inside {MD_OP_DIV, MD_OP_DIVU}) ? quo_fixed : rem_fixed;
    end

    assign busy_o = rst_ni && (start_ok || state_q == MD_MUL || state_q == MD_DIV);

    ex_div_core u_div_core (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .load      (div_load),
        .step      (state_q == MD_DIV),
        .clear     (div_clear),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done      (core_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= MD_IDLE;
            op_q        <= MD_OP_NONE;
            a_q         <= '0;
            b_q         <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            md_result_o <= '0;
            md_valid_o  <= 1'b0;
        end else begin
            md_valid_o <= 1'b0;
            unique case (state_q)
                MD_IDLE: begin
                    if (start_ok) begin
                        op_q    <= md_operate_i;
                        a_q     <= md_operand_a_i;
                        b_q     <= md_operand_b_i;
                        a_neg_q <= a_sgn;
                        b_neg_q <= b_sgn;
                        if (md_is_mul(md_operate_i)) begin
                            state_q <= MD_MUL;
                        end else if (is_special) begin
                            md_result_o <= special_res;
                            md_valid_o  <= 1'b1;
                            state_q     <= MD_DONE;
                        end else begin
                            state_q <= MD_DIV;
                        end
                    end
                end
                MD_MUL: begin
                    if (flush_i) begin
                        state_q <= MD_IDLE;
                    end else begin
                        md_result_o <= mul_res;
                        md_valid_o  <= 1'b1;
                        state_q     <= MD_DONE;
                    end
                end
                MD_DIV: begin
                    if (flush_i) begin
                        state_q <= MD_IDLE;
                    end else if (core_done) begin
                        md_result_o <= div_res;
                        md_valid_o  <= 1'b1;
                        state_q     <= MD_DONE;
                    end
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - self-checking bench for ex_mdu against an arithmetic reference model
`timescale 1ns/1ps
module tb_ex_mdu;
    import milano_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        md_sel;
    logic [31:0] opa;
    logic [31:0] opb;
    md_opt_e     md_op;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    ex_mdu dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .md_sel_i       (md_sel),
        .md_operand_a_i (opa),
        .md_operand_b_i (opb),
        .md_operate_i   (md_op),
        .flush_i        (flush),
        .busy_o         (busy),
        .md_valid_o     (valid),
        .md_result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_res(md_opt_e op, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        case (op)
            MD_OP_MUL:    begin p = sa * sb; return p[31:0]; end
            MD_OP_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            MD_OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            MD_OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            MD_OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            MD_OP_REMU: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(md_opt_e op, logic [31:0] a, logic [31:0] b);
        if (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU}) return 2;
        if (b == 32'd0) return 1;
        if ((op == MD_OP_DIV || op == MD_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents an op at the current cycle and holds it through DONE; returns in the cycle after DONE
    task automatic run_op(input md_opt_e op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        bit got;
        md_sel = 1'b1;
        md_op  = op;
        opa    = a;
        opb    = b;
        flush  = 1'b0;
        #1;
        check("busy_start", 32'(busy), 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid === 1'b1) got = 1;
            else check("busy_wait", 32'(busy), 32'd1);
        end
        check("latency", 32'(lat), 32'(model_lat(op, a, b)));
        check("result", result, model_res(op, a, b));
        check("busy_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("valid_pulse", 32'(valid), 32'd0);
    endtask

    task automatic idle_cycle();
        md_sel = 1'($urandom_range(0, 1));
        md_op  = md_sel ? MD_OP_NONE : md_opt_e'($urandom_range(1, 8));
        #1;
        check("busy_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("valid_idle", 32'(valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        md_opt_e     rop;

        rst_n  = 1'b0;
        md_sel = 1'b1;
        md_op  = MD_OP_MUL;
        opa    = 32'd3;
        opb    = 32'd4;
        flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        md_sel = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;

        run_op(MD_OP_MUL,   32'd7,          32'hFFFF_FFFD);
        run_op(MD_OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op(MD_OP_DIV,   32'hFFFF_FFEC,  32'd3);
        run_op(MD_OP_REM,   32'hFFFF_FFEC,  32'd3);
        run_op(MD_OP_DIVU,  32'd100,        32'd7);
        run_op(MD_OP_DIVU,  32'd5,          32'd0);
        run_op(MD_OP_REM,   32'd5,          32'd0);
        run_op(MD_OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF);
        run_op(MD_OP_REM,   32'h8000_0000,  32'hFFFF_FFFF);
        run_op(MD_OP_MULH,  32'h8000_0000,  32'h8000_0000);
        run_op(MD_OP_MULHSU,32'hFFFF_FFFF,  32'hFFFF_FFFF);
        idle_cycle();

        md_sel = 1'b1;
        md_op  = MD_OP_DIV;
        opa    = 32'hFFFF_FFEC;
        opb    = 32'd3;
        #1;
        check("flush_busy_start", 32'(busy), 32'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("flush_busy_run", 32'(busy), 32'd1);
            check("flush_no_valid", 32'(valid), 32'd0);
        end
        md_sel = 1'b0;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("flush_valid2", 32'(valid), 32'd0);
        run_op(MD_OP_MUL, 32'd12345, 32'd678);
        idle_cycle();

        md_sel = 1'b1;
        md_op  = MD_OP_DIVU;
        opa    = 32'd1000;
        opb    = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        md_sel = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_op(MD_OP_DIVU, 32'd1000, 32'd7);

        for (int i = 0; i < 60; i++) begin
            rop = md_opt_e'($urandom_range(1, 8));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        md_sel = 1'b0;
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
